// File: rtl/fm_receiver.sv
// FM quadrature demodulator: packed I/Q stream in, mono audio duplicated to L/R out, AXI-Lite config/status.
// One cycle from input accept to output valid; input stalls while the output register holds an untaken beat.
module fm_receiver #(
  parameter int FRAME_LEN = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [31:0] iq_in_V_TDATA,
  input  logic        iq_in_V_TVALID,
  output logic        iq_in_V_TREADY,
  output logic [31:0] audio_out_V_TDATA,
  output logic        audio_out_V_TVALID,
  input  logic        audio_out_V_TREADY,
  output logic [3:0]  led_out_V,
  input  logic [5:0]  s_axi_API_AWADDR,
  input  logic        s_axi_API_AWVALID,
  output logic        s_axi_API_AWREADY,
  input  logic [31:0] s_axi_API_WDATA,
  input  logic        s_axi_API_WVALID,
  output logic        s_axi_API_WREADY,
  output logic [1:0]  s_axi_API_BRESP,
  output logic        s_axi_API_BVALID,
  input  logic        s_axi_API_BREADY,
  input  logic [5:0]  s_axi_API_ARADDR,
  input  logic        s_axi_API_ARVALID,
  output logic        s_axi_API_ARREADY,
  output logic [31:0] s_axi_API_RDATA,
  output logic [1:0]  s_axi_API_RRESP,
  output logic        s_axi_API_RVALID,
  input  logic        s_axi_API_RREADY
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;
  logic   start, frame_end, running;

  logic [CW-1:0]      in_cnt, out_cnt;
  logic signed [15:0] prev_i, prev_q, cur_i, cur_q;
  logic signed [32:0] prod_a, prod_b, diff, shifted;
  logic               sat_hi, sat_lo, sat_hit;
  logic [15:0]        sample;
  logic               in_acc, out_hs;
  logic               out_vld;
  logic [31:0]        out_dat;
  logic               sat_sticky, done_sticky;
  logic [31:0]        sample_count;

  logic [4:0]  shift;
  logic        mute;
  logic [3:0]  led_val;
  logic        led_ovr;
  logic        wr_acc, rd_acc;
  logic        bvalid, rvalid, axi_live;
  logic [31:0] rdata, rd_mux;
  logic        unused_wdata;

  // ---------------- block control ----------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ap_start) begin
          state_nxt = S_RUN;
          start     = 1'b1;
        end
      end
      S_RUN: begin
        if (out_hs && (out_cnt == LAST_C)) begin
          state_nxt = S_DONE;
          frame_end = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign running  = (state == S_RUN);
  assign ap_idle  = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);
  assign ap_ready = (state == S_DONE);

  // ---------------- demodulator datapath ----------------
  assign iq_in_V_TREADY = running && (in_cnt < LEN_C) && (!out_vld || audio_out_V_TREADY);
  assign in_acc         = iq_in_V_TVALID && iq_in_V_TREADY;
  assign out_hs         = out_vld && audio_out_V_TREADY;

  assign cur_i = iq_in_V_TDATA[15:0];
  assign cur_q = iq_in_V_TDATA[31:16];

  // Cross product of consecutive phasors approximates instantaneous frequency.
  assign prod_a  = 33'(cur_q) * 33'(prev_i);
  assign prod_b  = 33'(cur_i) * 33'(prev_q);
  assign diff    = prod_a - prod_b;
  assign shifted = diff >>> shift;
  assign sat_hi  = (shifted > 33'sd32767);
  assign sat_lo  = (shifted < -33'sd32768);
  assign sat_hit = sat_hi || sat_lo;

  always_comb begin
    sample = shifted[15:0];
    if (sat_hi) sample = 16'h7FFF;
    if (sat_lo) sample = 16'h8000;
    if (mute)   sample = 16'h0000;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prev_i       <= '0;
      prev_q       <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      out_vld      <= 1'b0;
      out_dat      <= '0;
      sat_sticky   <= 1'b0;
      done_sticky  <= 1'b0;
      sample_count <= '0;
    end else begin
      if (start) begin
        prev_i      <= '0;
        prev_q      <= '0;
        in_cnt      <= '0;
        out_cnt     <= '0;
        sat_sticky  <= 1'b0;
        done_sticky <= 1'b0;
      end else begin
        if (in_acc) begin
          prev_i <= cur_i;
          prev_q <= cur_q;
          in_cnt <= in_cnt + CW'(1);
          if (sat_hit) sat_sticky <= 1'b1;
        end
        if (out_hs)    out_cnt     <= out_cnt + CW'(1);
        if (frame_end) done_sticky <= 1'b1;
      end
      if (in_acc) sample_count <= sample_count + 32'd1;
      // A fresh beat may replace the one being taken in the same cycle.
      if (in_acc) begin
        out_vld <= 1'b1;
        out_dat <= {sample, sample};
      end else if (out_hs) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign audio_out_V_TDATA  = out_dat;
  assign audio_out_V_TVALID = out_vld;

  assign led_out_V = led_ovr ? led_val : {out_vld, done_sticky, sat_sticky, running};

  // ---------------- AXI-Lite register slave ----------------
  assign wr_acc            = s_axi_API_AWVALID && s_axi_API_WVALID && !bvalid;
  assign s_axi_API_AWREADY = wr_acc;
  assign s_axi_API_WREADY  = wr_acc;
  assign s_axi_API_BVALID  = bvalid;
  assign s_axi_API_BRESP   = 2'b00;

  // axi_live keeps ARREADY low while reset is asserted.
  assign s_axi_API_ARREADY = axi_live && !rvalid;
  assign rd_acc            = s_axi_API_ARVALID && s_axi_API_ARREADY;
  assign s_axi_API_RVALID  = rvalid;
  assign s_axi_API_RDATA   = rdata;
  assign s_axi_API_RRESP   = 2'b00;

  assign unused_wdata = ^{s_axi_API_WDATA[31:9], s_axi_API_WDATA[7:5]};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      shift   <= 5'd15;
      mute    <= 1'b0;
      led_val <= 4'h0;
      led_ovr <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      if (wr_acc) begin
        bvalid <= 1'b1;
        case (s_axi_API_AWADDR)
          6'h10: begin
            shift <= s_axi_API_WDATA[4:0];
            mute  <= s_axi_API_WDATA[8];
          end
          6'h14: begin
            led_val <= s_axi_API_WDATA[3:0];
            led_ovr <= s_axi_API_WDATA[4];
          end
          default: ;
        endcase
      end else if (bvalid && s_axi_API_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_API_ARADDR)
      6'h00:   rd_mux = 32'h464D5258;
      6'h10:   rd_mux = {23'b0, mute, 3'b0, shift};
      6'h14:   rd_mux = {27'b0, led_ovr, led_val};
      6'h18:   rd_mux = sample_count;
      6'h20:   rd_mux = {13'b0, done_sticky, sat_sticky, running, out_dat[15:0]};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      axi_live <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      axi_live <= 1'b1;
      if (rd_acc) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
      end else if (rvalid && s_axi_API_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fm_receiver.sv
// Directed bench for fm_receiver: reset state, demod arithmetic, saturation, mute, register map,
// stream backpressure and mid-frame reset.
module tb_fm_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ap_start, ap_done, ap_idle, ap_ready;
  logic [31:0] iq_tdata;
  logic        iq_tvalid, iq_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid, out_rdy;
  logic [3:0]  led;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int rdy_mis = 0;

  always #5 clk = ~clk;

  fm_receiver #(.FRAME_LEN(16)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .iq_in_V_TDATA(iq_tdata), .iq_in_V_TVALID(iq_tvalid), .iq_in_V_TREADY(iq_tready),
    .audio_out_V_TDATA(out_tdata), .audio_out_V_TVALID(out_tvalid), .audio_out_V_TREADY(out_rdy),
    .led_out_V(led),
    .s_axi_API_AWADDR(awaddr), .s_axi_API_AWVALID(awvalid), .s_axi_API_AWREADY(awready),
    .s_axi_API_WDATA(wdata), .s_axi_API_WVALID(wvalid), .s_axi_API_WREADY(wready),
    .s_axi_API_BRESP(bresp), .s_axi_API_BVALID(bvalid), .s_axi_API_BREADY(bready),
    .s_axi_API_ARADDR(araddr), .s_axi_API_ARVALID(arvalid), .s_axi_API_ARREADY(arready),
    .s_axi_API_RDATA(rdata), .s_axi_API_RRESP(rresp), .s_axi_API_RVALID(rvalid),
    .s_axi_API_RREADY(rready)
  );

  always @(negedge clk) begin
    if (ap_done === 1'b1) done_pulses <= done_pulses + 1;
    if (ap_ready !== ap_done) rdy_mis <= rdy_mis + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic signed [15:0] pi, pq, ci, cq, input int sh);
    logic signed [32:0] d, s;
    logic [15:0] r;
    d = 33'(cq) * 33'(pi) - 33'(ci) * 33'(pq);
    s = d >>> sh;
    if (s > 33'sd32767)       r = 16'h7FFF;
    else if (s < -33'sd32768) r = 16'h8000;
    else                      r = s[15:0];
    return {r, r};
  endfunction

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d);
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept", {31'b0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", {31'b0, bvalid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("r_valid", {31'b0, rvalid}, 32'd1);
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    @(posedge clk); #1; ap_start = 1'b1;
    @(posedge clk); #1; ap_start = 1'b0;
    chk("started", {31'b0, ap_idle}, 32'd0);
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    iq_tdata = d; iq_tvalid = 1'b1;
    @(negedge clk);
    while (iq_tready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("in_accept", {31'b0, iq_tready}, 32'd1);
    @(posedge clk); #1;
    iq_tvalid = 1'b0;
  endtask

  task automatic get_out(input string tag, input logic [31:0] e);
    int n = 0;
    @(negedge clk);
    while (out_tvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, {31'b0, out_tvalid}, 32'd1);
    chk(tag, out_tdata, e);
    @(posedge clk); #1;
  endtask

  task automatic collect(input logic [31:0] e [16], input logic [15:0] pat);
    int got = 0;
    int cyc = 0;
    logic held_v = 1'b0;
    logic [31:0] held = '0;
    while (got < 16 && cyc < 500) begin
      @(posedge clk); #1;
      out_rdy = pat[cyc % 16];
      @(negedge clk);
      if (held_v) begin
        chk("stall_vld", {31'b0, out_tvalid}, 32'd1);
        chk("stall_dat", out_tdata, held);
      end
      held_v = 1'b0;
      if (out_tvalid === 1'b1) begin
        if (out_rdy) begin
          chk($sformatf("f1_out%0d", got), out_tdata, e[got]);
          got++;
        end else begin
          held_v = 1'b1;
          held = out_tdata;
        end
      end
      cyc++;
    end
    chk("f1_count", 32'(got), 32'd16);
    @(posedge clk); #1;
    out_rdy = 1'b1;
  endtask

  initial begin
    logic [31:0] vec [16];
    logic [31:0] exp [16];
    logic [31:0] rd;
    logic signed [15:0] pi, pq;
    int base;

    rst_n = 1'b0; ap_start = 1'b0; iq_tdata = '0; iq_tvalid = 1'b0; out_rdy = 1'b0;
    awaddr = '0; wdata = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (3) @(posedge clk); #1;
    chk("rst_idle", {31'b0, ap_idle}, 32'd1);
    chk("rst_done", {31'b0, ap_done}, 32'd0);
    chk("rst_in_rdy", {31'b0, iq_tready}, 32'd0);
    chk("rst_out_vld", {31'b0, out_tvalid}, 32'd0);
    chk("rst_led", {28'b0, led}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(6'h10, rd); chk("cfg_reset", rd, 32'h0000000F);
    axi_read(6'h00, rd); chk("id", rd, 32'h464D5258);

    // Frame 1: SHIFT=15, 16 beats against a stalling sink.
    vec[0] = 32'h00000100;
    vec[1] = 32'h01000000;
    for (int k = 2; k < 16; k++) vec[k] = {16'(300 - k * 50), 16'(k * 100 - 700)};
    exp[0] = 32'h00000000;
    exp[1] = 32'h00020002;
    pi = vec[1][15:0]; pq = vec[1][31:16];
    for (int k = 2; k < 16; k++) begin
      exp[k] = model(pi, pq, vec[k][15:0], vec[k][31:16], 15);
      pi = vec[k][15:0]; pq = vec[k][31:16];
    end
    base = done_pulses;
    start_frame();
    fork
      begin
        for (int k = 0; k < 16; k++) send_beat(vec[k]);
      end
      collect(exp, 16'b1011_0110_1101_0011);
    join
    repeat (3) @(posedge clk); #1;
    chk("f1_done_once", 32'(done_pulses - base), 32'd1);
    chk("ready_eq_done", 32'(rdy_mis), 32'd0);
    chk("f1_idle", {31'b0, ap_idle}, 32'd1);
    chk("f1_no_extra", {31'b0, out_tvalid}, 32'd0);
    chk("f1_led", {28'b0, led}, 32'h4);
    axi_read(6'h18, rd); chk("sample_count", rd, 32'd16);
    axi_read(6'h20, rd); chk("f1_status", rd, {13'b0, 1'b1, 1'b0, 1'b0, exp[15][15:0]});

    // Frame 2: SHIFT=0 saturation, register writes, mute.
    axi_write(6'h10, 32'h00000000);
    start_frame();
    out_rdy = 1'b1;
    send_beat(32'h00007FFF); get_out("f2_out0", 32'h00000000);
    axi_read(6'h20, rd); chk("f2_status0", rd, 32'h00010000);
    send_beat(32'h7FFF0000); get_out("f2_sat", 32'h7FFF7FFF);
    axi_read(6'h20, rd); chk("f2_status1", rd, 32'h00037FFF);
    chk("f2_led", {28'b0, led}, 32'h3);
    axi_write(6'h10, 32'h12345678);
    axi_read(6'h10, rd); chk("cfg_mask", rd, 32'h00000018);
    axi_write(6'h14, 32'h0000001A);
    chk("led_ovr", {28'b0, led}, 32'hA);
    axi_read(6'h14, rd); chk("led_ctrl_rd", rd, 32'h0000001A);
    axi_write(6'h10, 32'h00000100);
    axi_read(6'h10, rd); chk("cfg_mute", rd, 32'h00000100);
    send_beat(32'h40004000); get_out("f2_mute", 32'h00000000);
    axi_write(6'h3C, 32'hFFFFFFFF);
    axi_read(6'h3C, rd); chk("unmapped", rd, 32'h00000000);

    // Reset while a beat is held in the output register.
    out_rdy = 1'b0;
    send_beat(32'h00010001);
    chk("held_before_rst", {31'b0, out_tvalid}, 32'd1);
    base = done_pulses;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'b0, out_tvalid}, 32'd0);
    chk("mid_rst_in_rdy", {31'b0, iq_tready}, 32'd0);
    chk("mid_rst_idle", {31'b0, ap_idle}, 32'd1);
    chk("mid_rst_led", {28'b0, led}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(6'h10, rd); chk("cfg_after_rst", rd, 32'h0000000F);
    axi_read(6'h18, rd); chk("count_after_rst", rd, 32'd0);
    start_frame();
    out_rdy = 1'b1;
    send_beat(32'h12345678); get_out("post_rst_out0", 32'h00000000);
    chk("no_done_on_abort", 32'(done_pulses - base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
